// File: rtl/clz_pkg.sv
// -----------------------------------------------------------------------------
// clz_pkg
// Shared definitions for the CLZ scheduler slice: datapath widths, the result
// count width and the scheduler FSM state type.
// -----------------------------------------------------------------------------
package clz_pkg;

   localparam int unsigned CLZ_WIDTH   = 32;  // width of the shared CLZ datapath
   localparam int unsigned WIDE_WIDTH  = 64;  // widest operand a requester may submit
   localparam int unsigned COUNT_WIDTH = 7;   // holds 0..64

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PASS_HI,
      ST_PASS_LO,
      ST_RESP
   } clz_sched_state_t;

endpackage : clz_pkg

// File: rtl/clz_rr_arbiter.sv
// -----------------------------------------------------------------------------
// clz_rr_arbiter
// Round-robin arbiter with a registered priority pointer.
//   clk_i     : clock
//   rst_i     : asynchronous active-high reset (pointer -> 0)
//   req_i     : request vector
//   advance_i : a grant was taken this cycle; pointer moves past the winner
//   grant_o   : one-hot grant, searched from the pointer upward with wrap
//   idx_o     : encoded index of the granted requester
// -----------------------------------------------------------------------------
module clz_rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               advance_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   idx_o
);

   localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W:0]   w_pos;
   logic             w_found;

   // Walk the requesters starting at the pointer; one extra bit on w_pos lets
   // the sum exceed NUM_REQ before the wrap subtraction.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      w_pos   = '0;
      w_found = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_pos = {1'b0, r_ptr} + (IDX_W+1)'(i);
         if (w_pos >= NUM_REQ_W) begin
            w_pos = w_pos - NUM_REQ_W;
         end
         if (!w_found && req_i[w_pos[IDX_W-1:0]]) begin
            grant_o[w_pos[IDX_W-1:0]] = 1'b1;
            idx_o                     = w_pos[IDX_W-1:0];
            w_found                   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ptr <= '0;
      end else if (advance_i) begin
         r_ptr <= (idx_o == LAST_IDX) ? '0 : idx_o + 1'b1;
      end
   end

endmodule : clz_rr_arbiter

// File: rtl/count_leading_zeros.sv
// -----------------------------------------------------------------------------
// count_leading_zeros
// Combinational leading-zero counter.
//   data_i  : operand
//   count_o : number of zeros above the most significant one (0 when all zero)
//   zero_o  : operand is all zero; callers use this to form the full count
// -----------------------------------------------------------------------------
module count_leading_zeros #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [CNT_WIDTH-1:0]  count_o,
   output logic                  zero_o
);

   logic w_found;

   always_comb begin
      count_o = '0;
      w_found = 1'b0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         if (!w_found && data_i[DATA_WIDTH-1-i]) begin
            count_o = CNT_WIDTH'(i);
            w_found = 1'b1;
         end
      end
   end

   assign zero_o = ~|data_i;

endmodule : count_leading_zeros

// File: rtl/clz_scheduler.sv
// -----------------------------------------------------------------------------
// clz_scheduler
// Shares one 32-bit count_leading_zeros unit between NUM_REQ requesters.
// 64-bit operands take two passes (upper word first, early exit when the
// upper word holds a one). Results are registered and tagged with the owner.
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   req_valid_i     : per-requester request valid
//   req_wide_i      : per-requester 1 = 64-bit operand, 0 = 32-bit ([31:0])
//   req_operand_i   : per-requester operand
//   req_ready_o     : one-hot accept, only in IDLE
//   rsp_valid_o     : result valid, held until rsp_ready_i
//   rsp_ready_i     : consumer accepts result
//   rsp_id_o        : owner of the result
//   rsp_count_o     : leading-zero count 0..64
//   rsp_all_zero_o  : requested operand width was all zero
// -----------------------------------------------------------------------------
module clz_scheduler
   import clz_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [NUM_REQ-1:0]                req_valid_i,
   input  logic [NUM_REQ-1:0]                req_wide_i,
   input  logic [NUM_REQ-1:0][WIDE_WIDTH-1:0] req_operand_i,
   output logic [NUM_REQ-1:0]                req_ready_o,
   output logic                              rsp_valid_o,
   input  logic                              rsp_ready_i,
   output logic [ID_W-1:0]                   rsp_id_o,
   output logic [COUNT_WIDTH-1:0]            rsp_count_o,
   output logic                              rsp_all_zero_o
);

   localparam int unsigned CLZ_CNT_W = $clog2(CLZ_WIDTH);
   localparam logic [COUNT_WIDTH-1:0] WORD_ZERO_CNT = COUNT_WIDTH'(CLZ_WIDTH);

   clz_sched_state_t r_state;
   clz_sched_state_t w_next;

   logic [WIDE_WIDTH-1:0]  r_operand;
   logic                   r_wide;
   logic [ID_W-1:0]        r_id;
   logic                   r_hi_zero;
   logic [COUNT_WIDTH-1:0] r_count;
   logic                   r_all_zero;

   logic [NUM_REQ-1:0]     w_grant;
   logic [ID_W-1:0]        w_idx;
   logic                   w_accept;
   logic [CLZ_WIDTH-1:0]   w_clz_in;
   logic [CLZ_CNT_W-1:0]   w_clz_cnt;
   logic                   w_clz_zero;

   // ---------------------------------------------------------------- arbiter
   clz_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (ID_W)
   ) u_arb (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (req_valid_i),
      .advance_i (w_accept),
      .grant_o   (w_grant),
      .idx_o     (w_idx)
   );

   // Grant is a subset of the valids, so any ready bit means an accept.
   assign req_ready_o = (r_state == ST_IDLE && !rst_i) ? w_grant : '0;
   assign w_accept    = |req_ready_o;

   // ---------------------------------------------------------------- datapath
   assign w_clz_in = (r_state == ST_PASS_HI) ? r_operand[WIDE_WIDTH-1:CLZ_WIDTH]
                                             : r_operand[CLZ_WIDTH-1:0];

   count_leading_zeros #(
      .DATA_WIDTH (CLZ_WIDTH),
      .CNT_WIDTH  (CLZ_CNT_W)
   ) u_clz (
      .data_i  (w_clz_in),
      .count_o (w_clz_cnt),
      .zero_o  (w_clz_zero)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next = req_wide_i[w_idx] ? ST_PASS_HI : ST_PASS_LO;
            end
         end
         ST_PASS_HI: w_next = w_clz_zero ? ST_PASS_LO : ST_RESP;
         ST_PASS_LO: w_next = ST_RESP;
         ST_RESP: begin
            if (rsp_ready_i) begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- result
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_operand  <= '0;
         r_wide     <= 1'b0;
         r_id       <= '0;
         r_hi_zero  <= 1'b0;
         r_count    <= '0;
         r_all_zero <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_operand <= req_operand_i[w_idx];
                  r_wide    <= req_wide_i[w_idx];
                  r_id      <= w_idx;
                  r_hi_zero <= 1'b0;
               end
            end
            ST_PASS_HI: begin
               if (w_clz_zero) begin
                  r_hi_zero <= 1'b1;
               end else begin
                  r_count    <= COUNT_WIDTH'(w_clz_cnt);
                  r_all_zero <= 1'b0;
               end
            end
            ST_PASS_LO: begin
               // r_hi_zero is only ever set on the wide path, so narrow
               // operands see a zero upper contribution.
               r_count    <= (r_hi_zero  ? WORD_ZERO_CNT : '0) +
                             (w_clz_zero ? WORD_ZERO_CNT : COUNT_WIDTH'(w_clz_cnt));
               r_all_zero <= w_clz_zero && (!r_wide || r_hi_zero);
            end
            default: ;
         endcase
      end
   end

   assign rsp_valid_o    = (r_state == ST_RESP);
   assign rsp_id_o       = r_id;
   assign rsp_count_o    = r_count;
   assign rsp_all_zero_o = r_all_zero;

endmodule : clz_scheduler

// File: tb/tb_clz_scheduler.sv
// -----------------------------------------------------------------------------
// tb_clz_scheduler
// Directed stimulus against clz_scheduler with a transaction-level model that
// predicts grants, response latency and result fields every cycle.
// -----------------------------------------------------------------------------
module tb_clz_scheduler;

   localparam int N = 4;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic [N-1:0]        vld = '0;
   logic [N-1:0]        wide = '0;
   logic [N-1:0][63:0]  op = '0;
   logic [N-1:0]        rdy;
   logic                rsp_valid;
   logic                rsp_ready = 1'b1;
   logic [1:0]          rsp_id;
   logic [6:0]          rsp_count;
   logic                rsp_all_zero;

   always #5 clk = ~clk;

   clz_scheduler #(.NUM_REQ(N)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .req_valid_i    (vld),
      .req_wide_i     (wide),
      .req_operand_i  (op),
      .req_ready_o    (rdy),
      .rsp_valid_o    (rsp_valid),
      .rsp_ready_i    (rsp_ready),
      .rsp_id_o       (rsp_id),
      .rsp_count_o    (rsp_count),
      .rsp_all_zero_o (rsp_all_zero)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------ reference
   function automatic int ref_count(input logic [63:0] o, input bit w);
      int n = 0;
      int width = w ? 64 : 32;
      for (int i = width - 1; i >= 0; i--) begin
         if (o[i]) return n;
         n++;
      end
      return n;
   endfunction

   function automatic bit ref_zero(input logic [63:0] o, input bit w);
      return w ? (o == 64'd0) : (o[31:0] == 32'd0);
   endfunction

   // Cycles from the accepting cycle to the first cycle with a valid result.
   function automatic int ref_lat(input logic [63:0] o, input bit w);
      return (w && o[63:32] == 32'd0) ? 3 : 2;
   endfunction

   function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
      for (int i = 0; i < N; i++) begin
         int j = (ptr + i) % N;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   typedef struct {
      int id;
      int cnt;
      bit az;
   } rsp_t;

   int     m_ptr = 0;
   bit     m_busy = 1'b0;
   int     m_acc, m_lat, m_id, m_cnt;
   bit     m_az;
   int     cyc = 0;
   int     g;
   logic [N-1:0] eg;
   int     acc_log[$];
   rsp_t   rsp_log[$];

   // ------------------------------------------------------------ compare
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_ready", rdy, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_rsp_count", rsp_count, 0);
         chk("rst_rsp_id", rsp_id, 0);
         chk("rst_rsp_all_zero", rsp_all_zero, 0);
         m_ptr  = 0;
         m_busy = 1'b0;
      end else begin
         cyc++;
         if (!m_busy) begin
            g  = rr_pick(m_ptr, vld);
            eg = '0;
            if (g >= 0) eg[g] = 1'b1;
            chk("grant", rdy, eg);
            chk("idle_rsp_valid", rsp_valid, 0);
            if (g >= 0) begin
               m_busy = 1'b1;
               m_acc  = cyc;
               m_id   = g;
               m_cnt  = ref_count(op[g], wide[g]);
               m_az   = ref_zero(op[g], wide[g]);
               m_lat  = ref_lat(op[g], wide[g]);
               m_ptr  = (g + 1) % N;
               acc_log.push_back(g);
            end
         end else begin
            chk("busy_ready", rdy, 0);
            if (cyc - m_acc < m_lat) begin
               chk("latency_valid_low", rsp_valid, 0);
            end else begin
               chk("rsp_valid", rsp_valid, 1);
               chk("rsp_id", rsp_id, m_id);
               chk("rsp_count", rsp_count, m_cnt);
               chk("rsp_all_zero", rsp_all_zero, m_az);
               if (rsp_ready) begin
                  rsp_log.push_back('{m_id, m_cnt, m_az});
                  m_busy = 1'b0;
               end
            end
         end
      end
   end

   // ------------------------------------------------------------ stimulus
   task automatic send(input int id, input bit w, input logic [63:0] o);
      bit got = 1'b0;
      vld[id]  = 1'b1;
      wide[id] = w;
      op[id]   = o;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (rdy[id]) begin
            got = 1'b1;
            break;
         end
      end
      chk("accept_seen", got, 1);
      @(posedge clk);
      #1;
      vld[id] = 1'b0;
   endtask

   task automatic wait_rsp();
      bit got = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (rsp_valid && rsp_ready) begin
            got = 1'b1;
            break;
         end
      end
      chk("rsp_seen", got, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic check_last(input string tag, input int id, input int cnt, input bit az);
      if (rsp_log.size() == 0) begin
         chk({tag, "_present"}, rsp_log.size(), 1);
      end else begin
         chk({tag, "_id"}, rsp_log[rsp_log.size()-1].id, id);
         chk({tag, "_count"}, rsp_log[rsp_log.size()-1].cnt, cnt);
         chk({tag, "_all_zero"}, rsp_log[rsp_log.size()-1].az, az);
      end
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      int base;
      int rbase;
      bit ok;

      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Hand-computed values pinning the reference functions.
      chk("pin_narrow_15", ref_count(64'h0000_0000_0001_0000, 1'b0), 15);
      chk("pin_wide_56", ref_count(64'h0000_0000_0000_00FF, 1'b1), 56);
      chk("pin_wide_msb", ref_count(64'h8000_0000_0000_0000, 1'b1), 0);
      chk("pin_wide_zero", ref_count(64'd0, 1'b1), 64);
      chk("pin_narrow_zero", ref_count(64'hFFFF_FFFF_0000_0000, 1'b0), 32);
      chk("pin_lat_narrow", ref_lat(64'h0000_0000_0001_0000, 1'b0), 2);
      chk("pin_lat_wide_lo", ref_lat(64'h0000_0000_0000_00FF, 1'b1), 3);
      chk("pin_lat_wide_hi", ref_lat(64'h8000_0000_0000_0000, 1'b1), 2);

      send(2, 1'b0, 64'h0000_0000_0001_0000);
      wait_rsp();
      check_last("narrow_r2", 2, 15, 1'b0);

      send(0, 1'b1, 64'h0000_0000_0000_00FF);
      wait_rsp();
      check_last("wide_ff", 0, 56, 1'b0);

      send(3, 1'b1, 64'h8000_0000_0000_0000);
      wait_rsp();
      check_last("wide_msb", 3, 0, 1'b0);

      send(1, 1'b1, 64'd0);
      wait_rsp();
      check_last("wide_zero", 1, 64, 1'b1);

      // Upper word must be ignored for a narrow request.
      send(2, 1'b0, 64'hFFFF_FFFF_0000_0000);
      wait_rsp();
      check_last("narrow_zero", 2, 32, 1'b1);

      send(0, 1'b1, 64'h0000_0000_8000_0000);
      wait_rsp();
      check_last("wide_lo_msb", 0, 32, 1'b0);

      // Round-robin with all requesters continuously valid from pointer 0.
      pulse_reset();
      base  = acc_log.size();
      rbase = rsp_log.size();
      wide  = '0;
      for (int i = 0; i < N; i++) op[i] = 64'd1;
      vld = '1;
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (acc_log.size() >= base + 5) begin
            ok = 1'b1;
            break;
         end
      end
      chk("rr_five_grants", ok, 1);
      @(posedge clk);
      #1 vld = '0;
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (rsp_log.size() >= rbase + 5 && !m_busy) begin
            ok = 1'b1;
            break;
         end
      end
      chk("rr_five_rsps", ok, 1);
      if (ok) begin
         for (int i = 0; i < 5; i++) begin
            chk("rr_order", acc_log[base+i], i % N);
            chk("rr_count31", rsp_log[rbase+i].cnt, 31);
         end
      end
      @(posedge clk);
      #1;

      // Backpressure, then reset while holding the result.
      rsp_ready = 1'b0;
      send(1, 1'b0, 64'h0000_0000_00F0_0000);
      ok = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            ok = 1'b1;
            break;
         end
      end
      chk("bp_valid_seen", ok, 1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("bp_hold_valid", rsp_valid, 1);
         chk("bp_hold_id", rsp_id, 1);
         chk("bp_hold_count", rsp_count, 8);
      end
      rbase = rsp_log.size();
      pulse_reset();
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_valid", rsp_valid, 0);
      base = acc_log.size();
      op[0] = 64'd1;
      op[3] = 64'd1;
      vld[0] = 1'b1;
      vld[3] = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (acc_log.size() > base) begin
            ok = 1'b1;
            break;
         end
      end
      chk("post_rst_grant_seen", ok, 1);
      if (ok) chk("post_rst_grant", acc_log[base], 0);
      @(posedge clk);
      #1 vld = '0;
      wait_rsp();
      check_last("post_rst", 0, 31, 1'b0);
      chk("aborted_no_rsp", rsp_log.size(), rbase + 1);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_clz_scheduler
